// File: rtl/a2d_chnl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : a2d_chnl_seq                                                 |
// | Description : Round-robin conversion sequencer for the A2D SPI interface.  |
// |               Sweeps channels 0..NUM_CH-1, keeps one 12-bit result per     |
// |               channel and flags every slot update.                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk           system clock                                               |
// |   rst_n         asynchronous active-low reset                              |
// |   en_i          level, 1 = sweep continuously                              |
// |   strt_cnv_o    1-clk start pulse to the A2D interface                     |
// |   chnnl_o       channel being converted, stable for the whole conversion   |
// |   cnv_cmplt_i   conversion-complete level from the A2D interface           |
// |   res_i         conversion result, valid while cnv_cmplt_i=1              |
// |   ch_data_o     stored results, channel k at bits [12k+11:12k]             |
// |   smpl_vld_o    1-clk pulse when a slot has been updated                   |
// |   smpl_ch_o     channel just updated, valid with smpl_vld_o                |
// |   sweep_done_o  1-clk pulse after the last channel of a sweep              |
// |   tmo_err_o     sticky conversion-timeout flag, cleared only by reset      |
// +----------------------------------------------------------------------------+
// | Build option                                                               |
// |   A2D_SEQ_AVG_EN  when defined each slot is a 4-tap IIR filter:            |
// |                   new = (3*old + res + 2) >> 2, first sample loads direct. |
// +----------------------------------------------------------------------------+
module a2d_chnl_seq #(
  parameter int NUM_CH      = 8,
  parameter int GAP_CYC     = 1024,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  output logic                 strt_cnv_o,
  output logic [2:0]           chnnl_o,
  input  logic                 cnv_cmplt_i,
  input  logic [11:0]          res_i,
  output logic [NUM_CH*12-1:0] ch_data_o,
  output logic                 smpl_vld_o,
  output logic [2:0]           smpl_ch_o,
  output logic                 sweep_done_o,
  output logic                 tmo_err_o
);

  localparam int         GAP_W   = $clog2(GAP_CYC + 1);
  localparam int         TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    CONV  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         chnnl_q, chnnl_d;
  logic               strt_cnv_q, strt_cnv_d;
  logic               first_q, first_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [11:0]        slot_q [NUM_CH];
  logic [11:0]        slot_d [NUM_CH];
  logic               smpl_vld_q, smpl_vld_d;
  logic [2:0]         smpl_ch_q, smpl_ch_d;
  logic               sweep_done_q, sweep_done_d;
  logic               tmo_err_q, tmo_err_d;
  logic               conv_end;
`ifdef A2D_SEQ_AVG_EN
  logic [NUM_CH-1:0]  seen_q, seen_d;

  // 3*old + new + 2 peaks at 16382, so 14 bits never overflow.
  function automatic logic [11:0] avg4(input logic [11:0] old_v, input logic [11:0] new_v);
    logic [13:0] sum;
    sum = {2'b00, old_v} + {1'b0, old_v, 1'b0} + {2'b00, new_v} + 14'd2;
    return 12'(sum >> 2);
  endfunction
`endif

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    chnnl_d      = chnnl_q;
    strt_cnv_d   = 1'b0;
    first_d      = 1'b0;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    slot_d       = slot_q;
    smpl_vld_d   = 1'b0;
    smpl_ch_d    = smpl_ch_q;
    sweep_done_d = 1'b0;
    tmo_err_d    = tmo_err_q;
    conv_end     = 1'b0;
`ifdef A2D_SEQ_AVG_EN
    seen_d       = seen_q;
`endif

    case (state_q)
      IDLE: begin
        chnnl_d = '0;
        if (en_i) begin
          state_d    = START;
          strt_cnv_d = 1'b1;
        end
      end

      START: begin
        tmo_d   = TMO_W'(TIMEOUT_CYC);
        first_d = 1'b1;
        state_d = CONV;
      end

      CONV: begin
        // On the first CONV clk cnv_cmplt_i may still be the level left over
        // from the previous conversion, so it is ignored there.
        if (!first_q && cnv_cmplt_i) begin
          conv_end   = 1'b1;
          smpl_vld_d = 1'b1;
          smpl_ch_d  = chnnl_q;
          for (int k = 0; k < NUM_CH; k++) begin
            if (chnnl_q == 3'(k)) begin
`ifdef A2D_SEQ_AVG_EN
              slot_d[k] = seen_q[k] ? avg4(slot_q[k], res_i) : res_i;
              seen_d[k] = 1'b1;
`else
              slot_d[k] = res_i;
`endif
            end
          end
        end else if (tmo_q == '0) begin
          // Abandon the channel; its slot keeps the previous value.
          conv_end  = 1'b1;
          tmo_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end

        if (conv_end) begin
          if (!en_i) begin
            state_d = IDLE;
            chnnl_d = '0;
          end else if (chnnl_q < LAST_CH) begin
            chnnl_d    = chnnl_q + 3'd1;
            state_d    = START;
            strt_cnv_d = 1'b1;
          end else begin
            chnnl_d      = '0;
            sweep_done_d = 1'b1;
            gap_d        = GAP_W'(GAP_CYC);
            state_d      = GAP;
          end
        end
      end

      GAP: begin
        // GAP lasts exactly GAP_CYC clks; en_i is only looked at on the last.
        if (gap_q <= GAP_W'(1)) begin
          gap_d = '0;
          if (en_i) begin
            state_d    = START;
            strt_cnv_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      chnnl_q      <= '0;
      strt_cnv_q   <= 1'b0;
      first_q      <= 1'b0;
      tmo_q        <= '0;
      gap_q        <= '0;
      smpl_vld_q   <= 1'b0;
      smpl_ch_q    <= '0;
      sweep_done_q <= 1'b0;
      tmo_err_q    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        slot_q[k] <= '0;
      end
`ifdef A2D_SEQ_AVG_EN
      seen_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      chnnl_q      <= chnnl_d;
      strt_cnv_q   <= strt_cnv_d;
      first_q      <= first_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      smpl_vld_q   <= smpl_vld_d;
      smpl_ch_q    <= smpl_ch_d;
      sweep_done_q <= sweep_done_d;
      tmo_err_q    <= tmo_err_d;
      for (int k = 0; k < NUM_CH; k++) begin
        slot_q[k] <= slot_d[k];
      end
`ifdef A2D_SEQ_AVG_EN
      seen_q       <= seen_d;
`endif
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
      assign ch_data_o[12*k +: 12] = slot_q[k];
    end
  endgenerate

  assign strt_cnv_o   = strt_cnv_q;
  assign chnnl_o      = chnnl_q;
  assign smpl_vld_o   = smpl_vld_q;
  assign smpl_ch_o    = smpl_ch_q;
  assign sweep_done_o = sweep_done_q;
  assign tmo_err_o    = tmo_err_q;

endmodule
`default_nettype wire

// File: tb/tb_a2d_chnl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_a2d_chnl_seq                                              |
// | Description : Self-checking bench for a2d_chnl_seq with an A2D model,      |
// |               result scoreboard and reference slot model.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_a2d_chnl_seq;

  localparam int NUM_CH      = 8;
  localparam int GAP_CYC     = 20;
  localparam int TIMEOUT_CYC = 60;
  localparam int BUDGET      = 3000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic                 strt_cnv;
  logic [2:0]           chnnl;
  logic                 cnv_cmplt;
  logic [11:0]          res;
  logic [NUM_CH*12-1:0] ch_data;
  logic                 smpl_vld;
  logic [2:0]           smpl_ch;
  logic                 sweep_done;
  logic                 tmo_err;

  always #5 clk = ~clk;

  a2d_chnl_seq #(
    .NUM_CH      (NUM_CH),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .strt_cnv_o   (strt_cnv),
    .chnnl_o      (chnnl),
    .cnv_cmplt_i  (cnv_cmplt),
    .res_i        (res),
    .ch_data_o    (ch_data),
    .smpl_vld_o   (smpl_vld),
    .smpl_ch_o    (smpl_ch),
    .sweep_done_o (sweep_done),
    .tmo_err_o    (tmo_err)
  );

  typedef struct {
    int          ch;
    logic [11:0] val;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          vld_cnt = 0;
  int          sweep_cnt = 0;
  int          strt_cnt = 0;

  // Stimulus knobs shared with the A2D model
  int          exp_ch = 0;
  int          hang_ch = NUM_CH;
  int          res_mode = 0;
  int          fix_conv = 40;
  logic [11:0] ch0_val = 12'h000;

  // Reference slot contents (model side) and the monitor's view of ch_data
  int          ref_slot [NUM_CH];
  bit          ref_seen [NUM_CH];
  logic [11:0] exp_data [NUM_CH];

  // A2D model state
  int          m_cnt = 0;
  int          m_ch = 0;
  int          m_t = 0;
  bit          m_busy = 1'b0;
  bit          m_hang = 1'b0;
  logic [11:0] m_res;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [11:0] pick_res(input int ch);
    case (res_mode)
      0:       return 12'h100 + 12'(ch);
      2:       return (ch == 0) ? ch0_val : 12'($urandom);
      default: return 12'($urandom);
    endcase
  endfunction

  // Slot value the specification requires after a new sample r on channel ch.
  function automatic logic [11:0] ref_apply(input int ch, input logic [11:0] r);
    int v;
`ifdef A2D_SEQ_AVG_EN
    if (ref_seen[ch]) v = (3 * ref_slot[ch] + int'(r) + 2) / 4;
    else              v = int'(r);
`else
    v = int'(r);
`endif
    ref_seen[ch] = 1'b1;
    ref_slot[ch] = v;
    return 12'(v);
  endfunction

  function automatic logic [NUM_CH*12-1:0] pack_exp();
    logic [NUM_CH*12-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[12*k +: 12] = exp_data[k];
    return v;
  endfunction

  task automatic clear_models();
    sb_q.delete();
    for (int k = 0; k < NUM_CH; k++) begin
      ref_slot[k] = 0;
      ref_seen[k] = 1'b0;
      exp_data[k] = 12'h000;
    end
    exp_ch = 0;
  endtask

  // A2D interface model: holds cnv_cmplt from the previous conversion over
  // the next start, drops it one clk later, raises it with res after m_t clks.
  initial begin : a2d_model
    cnv_cmplt = 1'b0;
    res       = 12'h000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy    = 1'b0;
        cnv_cmplt = 1'b0;
      end else if (strt_cnv) begin
        strt_cnt++;
        chk("strt_chnnl", 128'(chnnl), 128'(exp_ch));
        m_ch   = exp_ch;
        exp_ch = (exp_ch + 1) % NUM_CH;
        m_busy = 1'b1;
        m_cnt  = 0;
        m_hang = (m_ch == hang_ch);
        m_t    = (fix_conv != 0) ? fix_conv : int'($urandom_range(40, 3));
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == 2) cnv_cmplt = 1'b0;
        if (!m_hang && m_cnt == m_t) begin
          m_res     = pick_res(m_ch);
          res       = m_res;
          cnv_cmplt = 1'b1;
          sb_q.push_back('{ch: m_ch, val: ref_apply(m_ch, m_res)});
          m_busy    = 1'b0;
        end
      end
    end
  end

  // Monitor: every smpl_vld pops the scoreboard and checks the whole ch_data.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sweep_done) sweep_cnt++;
        if (smpl_vld) begin
          vld_cnt++;
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL smpl_unexpected: actual ch=%0d required=no sample", smpl_ch);
          end else begin
            mon_e = sb_q.pop_front();
            exp_data[mon_e.ch] = mon_e.val;
            chk("smpl_ch", 128'(smpl_ch), 128'(mon_e.ch));
            chk("ch_data", 128'(ch_data), 128'(pack_exp()));
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string nm);
    chk({nm, "_ch_data"}, 128'(ch_data), 128'(0));
    chk({nm, "_chnnl"}, 128'(chnnl), 128'(0));
    chk({nm, "_strt"}, 128'(strt_cnv), 128'(0));
    chk({nm, "_vld"}, 128'(smpl_vld), 128'(0));
    chk({nm, "_sweep"}, 128'(sweep_done), 128'(0));
    chk({nm, "_tmo"}, 128'(tmo_err), 128'(0));
  endtask

  task automatic wait_sweep_done(input string nm);
    int t = 0;
    do begin @(negedge clk); t++; end while (!sweep_done && t < BUDGET);
    chk(nm, 128'(sweep_done), 128'(1));
  endtask

  task automatic wait_strt_ch(input int ch, input string nm);
    int t = 0;
    do begin @(negedge clk); t++; end while (!(strt_cnv && chnnl == 3'(ch)) && t < BUDGET);
    chk(nm, 128'(strt_cnv && chnnl == 3'(ch)), 128'(1));
  endtask

  logic [NUM_CH*12-1:0] exp1;
  logic [11:0]          s1, s2, s3;
  int                   d, t, s0, sc;

  initial begin : main
    rst_n = 1'b0;
    en    = 1'b0;
    clear_models();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Fixed 40-clk conversions, res = 0x100 + channel
    res_mode = 0;
    fix_conv = 40;
    en       = 1'b1;
    wait_sweep_done("sweep1_wait");
    d = 0;
    do begin @(negedge clk); d++; end while (!strt_cnv && d < GAP_CYC + 10);
    chk("gap_min", 128'(d >= GAP_CYC), 128'(1));
    chk("gap_max", 128'(d <= GAP_CYC + 2), 128'(1));
    for (int k = 0; k < NUM_CH; k++) exp1[12*k +: 12] = 12'h100 + 12'(k);
    chk("sweep1_data", 128'(ch_data), 128'(exp1));
    chk("sweep1_vld_cnt", 128'(vld_cnt), 128'(NUM_CH));
    chk("sweep1_done_cnt", 128'(sweep_cnt), 128'(1));

    // Random results and conversion times; channel 3 never completes once
    res_mode = 1;
    fix_conv = 0;
    hang_ch  = 3;
    t = 0;
    do begin @(negedge clk); t++; end while (!tmo_err && t < BUDGET);
    chk("tmo_set", 128'(tmo_err), 128'(1));
    chk("tmo_next_strt", 128'(strt_cnv), 128'(1));
    chk("tmo_next_ch", 128'(chnnl), 128'(4));
    chk("tmo_slot3_kept", 128'(ch_data[47:36]), 128'(exp_data[3]));
    hang_ch = NUM_CH;
    for (int i = 0; i < 4; i++) wait_sweep_done("rand_sweep_wait");
    chk("tmo_sticky", 128'(tmo_err), 128'(1));

    // Drop en during the channel 5 conversion
    fix_conv = 40;
    wait_strt_ch(5, "en_off_wait_ch5");
    repeat (5) @(negedge clk);
    en = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!(smpl_vld && smpl_ch == 3'd5) && t < BUDGET);
    chk("en_off_ch5_captured", 128'(smpl_vld && smpl_ch == 3'd5), 128'(1));
    s0 = strt_cnt;
    sc = sweep_cnt;
    repeat (120) @(negedge clk);
    chk("en_off_no_strt", 128'(strt_cnt), 128'(s0));
    chk("en_off_no_sweep", 128'(sweep_cnt), 128'(sc));
    chk("en_off_chnnl", 128'(chnnl), 128'(0));
    exp_ch = 0;

    // Reset during a conversion, then three sweeps feeding ch0 0x000, 0xFFF, 0xFFF
    res_mode = 2;
    fix_conv = 0;
    ch0_val  = 12'h000;
    en       = 1'b1;
    wait_strt_ch(2, "rst_wait_ch2");
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    clear_models();
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!strt_cnv && t < BUDGET);
    chk("rst_restart_ch0", 128'(strt_cnv && chnnl == 3'd0), 128'(1));

`ifdef A2D_SEQ_AVG_EN
    s1 = 12'h000; s2 = 12'h400; s3 = 12'h700;
`else
    s1 = 12'h000; s2 = 12'hFFF; s3 = 12'hFFF;
`endif
    wait_sweep_done("slot0_sweep1_wait");
    chk("slot0_sample1", 128'(ch_data[11:0]), 128'(s1));
    ch0_val = 12'hFFF;
    wait_sweep_done("slot0_sweep2_wait");
    chk("slot0_sample2", 128'(ch_data[11:0]), 128'(s2));
    wait_sweep_done("slot0_sweep3_wait");
    chk("slot0_sample3", 128'(ch_data[11:0]), 128'(s3));
    en = 1'b0;
    repeat (60) @(negedge clk);
    chk("sb_drained", 128'(sb_q.size()), 128'(0));
    chk("tmo_cleared_by_rst", 128'(tmo_err), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
